// File: rtl/pipo_ctrl_pkg.sv
// Shared types and constants for the PIPO load arbiter: FSM state encoding,
// default widths and the round-robin pointer wrap helper.
package pipo_ctrl_pkg;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_DATA_WIDTH = 4;
   localparam int HOLD_CNT_W     = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } pipo_state_e;

   // Index that follows v in a ring of n requesters.
   function automatic int wrap_inc(input int v, input int n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/pipo_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping, reported as one-hot, index and valid.
module pipo_rr_picker
   import pipo_ctrl_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               valid_o
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      // NOTE: every output gets a default before the loop, so no path through
      // this block can leave a value unassigned and infer a latch.
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         cand = IDX_W'((int'(ptr_i) + off) % NUM_REQ);
         if (!valid_o && req_i[cand]) begin
            grant_o[cand] = 1'b1;
            idx_o         = cand;
            valid_o       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pipo_load_arbiter.sv
// Round-robin owner of a shared PIPO register: grants one requester, strobes
// its data into the PIPO, holds ownership HOLD_CYCLES cycles, then pulses done.
module pipo_load_arbiter
   import pipo_ctrl_pkg::*;
#(
   parameter int NUM_REQ     = DEF_NUM_REQ,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int HOLD_CYCLES = 2
) (
   input  logic                          Clk_In,
   input  logic                          Reset_In,
   input  logic                          Enable_In,
   input  logic [NUM_REQ-1:0]            Req_In,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data_In,
   output logic [NUM_REQ-1:0]            Grant_Out,
   output logic [$clog2(NUM_REQ)-1:0]    Owner_Out,
   output logic [NUM_REQ-1:0]            Done_Out,
   output logic                          Busy_Out,
   output logic                          Pipo_Enable_Out,
   output logic                          Pipo_Load_Out,
   output logic [DATA_WIDTH-1:0]         Pipo_Data_Out
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [HOLD_CNT_W-1:0] CNT_ONE  = HOLD_CNT_W'(1);
   localparam logic [HOLD_CNT_W-1:0] CNT_INIT = HOLD_CNT_W'(HOLD_CYCLES);

   pipo_state_e             state_q;
   logic [HOLD_CNT_W-1:0]   cnt_q;
   logic [IDX_W-1:0]        rr_q;
   logic [NUM_REQ-1:0]      grant_q;
   logic [IDX_W-1:0]        owner_q;
   logic [NUM_REQ-1:0]      done_q;
   logic [DATA_WIDTH-1:0]   data_q;

   logic [NUM_REQ-1:0]      pick_oh;
   logic [IDX_W-1:0]        pick_idx;
   logic                    pick_valid;
   logic [DATA_WIDTH-1:0]   data_d;

   pipo_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req_i   (Req_In),
      .ptr_i   (rr_q),
      .grant_o (pick_oh),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   // Winner's data slice, captured only on the grant edge.
   always_comb begin
      data_d = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_oh[i]) data_d = Req_Data_In[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // NOTE: all state below uses non-blocking assignments so every register
   // samples the pre-edge values of the others, whatever the statement order.
   always_ff @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rr_q    <= '0;
         grant_q <= '0;
         owner_q <= '0;
         done_q  <= '0;
         data_q  <= '0;
      end else if (Enable_In) begin
         unique case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  state_q <= LOAD;
                  grant_q <= pick_oh;
                  owner_q <= pick_idx;
                  data_q  <= data_d;
               end
            end
            LOAD: begin
               cnt_q <= CNT_INIT;
               if (HOLD_CYCLES == 0) begin
                  state_q <= DONE;
                  done_q  <= grant_q;
               end else begin
                  state_q <= HOLD;
               end
            end
            HOLD: begin
               cnt_q <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_q <= DONE;
                  done_q  <= grant_q;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= '0;
               grant_q <= '0;
               owner_q <= '0;
               rr_q    <= IDX_W'(wrap_inc(int'(owner_q), NUM_REQ));
            end
         endcase
      end
   end

   // The load strobe is gated so a frozen controller never re-strobes the PIPO.
   assign Pipo_Enable_Out = Enable_In;
   assign Pipo_Load_Out   = (state_q == LOAD) & Enable_In;
   assign Pipo_Data_Out   = data_q;
   assign Grant_Out       = grant_q;
   assign Owner_Out       = owner_q;
   assign Done_Out        = done_q;
   assign Busy_Out        = (state_q != IDLE);

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Scoreboard bench for pipo_load_arbiter: stimulus queues expected transactions,
// a monitor checks each done pulse against the queue head.
module tb_pipo_load_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [3:0]  req, req0;
   logic [15:0] req_data, req0_data;

   logic [3:0]  grant, done, grant0, done0;
   logic [1:0]  owner, owner0;
   logic        busy, pen, load, busy0, pen0, load0;
   logic [3:0]  pdata, pdata0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         owner;
      logic [3:0] data;
      int         len;
      int         gap;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   pipo_load_arbiter #(.NUM_REQ(4), .DATA_WIDTH(4), .HOLD_CYCLES(2)) u_dut (
      .Clk_In          (clk),
      .Reset_In        (rst),
      .Enable_In       (en),
      .Req_In          (req),
      .Req_Data_In     (req_data),
      .Grant_Out       (grant),
      .Owner_Out       (owner),
      .Done_Out        (done),
      .Busy_Out        (busy),
      .Pipo_Enable_Out (pen),
      .Pipo_Load_Out   (load),
      .Pipo_Data_Out   (pdata)
   );

   pipo_load_arbiter #(.NUM_REQ(4), .DATA_WIDTH(4), .HOLD_CYCLES(0)) u_dut0 (
      .Clk_In          (clk),
      .Reset_In        (rst),
      .Enable_In       (en),
      .Req_In          (req0),
      .Req_Data_In     (req0_data),
      .Grant_Out       (grant0),
      .Owner_Out       (owner0),
      .Done_Out        (done0),
      .Busy_Out        (busy0),
      .Pipo_Enable_Out (pen0),
      .Pipo_Load_Out   (load0),
      .Pipo_Data_Out   (pdata0)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic expect_txn(input int o, input logic [3:0] d, input int len, input int gap);
      exp_t e;
      e.owner = o;
      e.data  = d;
      e.len   = len;
      e.gap   = gap;
      exp_q.push_back(e);
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("wait_idle_timeout", 0, 1);
   endtask

   task automatic wait_grant(input logic [3:0] g);
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (grant == g) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("wait_grant_timeout", 0, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: samples 3 time units after each rising edge.
   int   in_txn = 0, len = 0, loads = 0, idle_cnt = 0, done_seen = 0;
   exp_t mon_e;

   always begin
      @(posedge clk);
      #3;
      if (rst) begin
         in_txn    = 0;
         done_seen = 0;
         idle_cnt  = 0;
      end else begin
         if (done_seen != 0) begin
            check("grant_clear_after_done", grant, 0);
            check("busy_clear_after_done", busy, 0);
            done_seen = 0;
         end
         if (grant != 0 && in_txn == 0) begin
            in_txn = 1;
            len    = 0;
            loads  = 0;
            if (exp_q.size() > 0 && exp_q[0].gap >= 0)
               check("idle_gap", idle_cnt, exp_q[0].gap);
         end
         if (in_txn != 0) len++;
         else idle_cnt++;
         if (load) loads++;
         if (done != 0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", done, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("done_onehot", done, 4'b0001 << mon_e.owner);
               check("grant_at_done", grant, 4'b0001 << mon_e.owner);
               check("owner_at_done", owner, mon_e.owner);
               check("pipo_data", pdata, mon_e.data);
               check("grant_length", len, mon_e.len);
               check("load_pulses", loads, 1);
               check("busy_at_done", busy, 1);
            end
            in_txn    = 0;
            done_seen = 1;
            idle_cnt  = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      en        = 1'b1;
      req       = '0;
      req_data  = '0;
      req0      = '0;
      req0_data = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_grant", grant, 0);
      check("rst_owner", owner, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_load", load, 0);
      check("rst_data", pdata, 0);
      rst = 1'b0;

      // Single request, zero-latency grant and load strobe.
      @(negedge clk);
      req_data = 16'h0A00;
      req      = 4'b0100;
      expect_txn(2, 4'hA, 4, -1);
      @(posedge clk); #1;
      check("single_grant", grant, 4'b0100);
      check("single_load", load, 1);
      check("single_data", pdata, 4'hA);
      @(negedge clk);
      req = '0;
      @(posedge clk); #1;
      check("single_load_off", load, 0);
      check("single_done_early1", done, 0);
      @(posedge clk); #1;
      check("single_done_early2", done, 0);
      @(posedge clk); #1;
      check("single_done_k3", done, 4'b0100);
      wait_idle();

      // Full contention from a fresh pointer: 0,1,2,3,0 with one idle cycle between.
      do_reset();
      @(negedge clk);
      req_data = 16'h4321;
      req      = 4'b1111;
      expect_txn(0, 4'h1, 4, -1);
      expect_txn(1, 4'h2, 4, 1);
      expect_txn(2, 4'h3, 4, 1);
      expect_txn(3, 4'h4, 4, 1);
      expect_txn(0, 4'h1, 4, 1);
      for (int i = 0; i < 200; i++) begin
         if (exp_q.size() <= 1) break;
         @(negedge clk);
      end
      wait_grant(4'b0001);
      req = '0;
      wait_idle();

      // Enable pause of three cycles during HOLD; pointer now at 1.
      @(negedge clk);
      req = 4'b0010;
      expect_txn(1, 4'h2, 7, -1);
      @(posedge clk);
      @(negedge clk);
      req = '0;
      @(negedge clk);
      en = 1'b0;
      #1;
      check("pause_pipo_enable", pen, 0);
      check("pause_no_load", load, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("pause_no_done", done, 0);
         check("pause_busy", busy, 1);
         check("pause_no_load_loop", load, 0);
      end
      en = 1'b1;
      @(posedge clk); #1;
      check("pause_done_not_yet", done, 0);
      @(posedge clk); #1;
      check("pause_done_delayed", done, 4'b0010);
      wait_idle();

      // Withdrawal and data change after the grant; wrap from pointer 2 to 1.
      @(negedge clk);
      req_data = 16'h0050;
      req      = 4'b0010;
      expect_txn(1, 4'h5, 4, -1);
      @(posedge clk); #1;
      check("withdraw_owner", owner, 1);
      @(posedge clk);
      @(negedge clk);
      req      = '0;
      req_data = 16'h00C0;
      wait_idle();

      // Async reset mid-HOLD: pointer 2 picks 3 first, after reset 0 wins.
      @(negedge clk);
      req_data = 16'h7006;
      req      = 4'b1001;
      @(posedge clk); #1;
      check("rr_wrap_grant", grant, 4'b1000);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_grant", grant, 0);
      check("arst_owner", owner, 0);
      check("arst_done", done, 0);
      check("arst_busy", busy, 0);
      check("arst_load", load, 0);
      check("arst_data", pdata, 0);
      expect_txn(0, 4'h6, 4, -1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_grant", grant, 4'b0001);
      check("post_rst_data", pdata, 4'h6);
      @(negedge clk);
      req = '0;
      wait_idle();

      // HOLD_CYCLES = 0 build: LOAD then DONE, grant high two cycles.
      @(negedge clk);
      req0_data = 16'h0B00;
      req0      = 4'b0100;
      @(posedge clk); #1;
      check("h0_grant", grant0, 4'b0100);
      check("h0_load", load0, 1);
      check("h0_done_early", done0, 0);
      check("h0_data", pdata0, 4'hB);
      @(negedge clk);
      req0 = '0;
      @(posedge clk); #1;
      check("h0_grant_done", grant0, 4'b0100);
      check("h0_load_off", load0, 0);
      check("h0_done", done0, 4'b0100);
      @(posedge clk); #1;
      check("h0_grant_clear", grant0, 0);
      check("h0_done_clear", done0, 0);
      check("h0_busy_clear", busy0, 0);
      check("h0_data_kept", pdata0, 4'hB);

      for (int i = 0; i < 50; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      check("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
